// File: rtl/ann_pkg.sv
// Shared constants and FSM state type for the ANN feature loader.
// Frame checksum support is selected with the ANN_FRAME_CHECKSUM_EN macro.
package ann_pkg;
  localparam int N_FEAT      = 8;
  localparam int FEAT_W      = 16;
  localparam int STAGE_W     = 2;
  localparam int FRAME_BYTES = 2 * N_FEAT;

  typedef enum logic [1:0] {
    RECV,
    SETTLE,
    CAPTURE,
    RESP
  } state_t;
endpackage

// File: rtl/ann_frame_assembler.sv
// Byte counter, shadow register and optional checksum for one frame.
// ANN_FRAME_CHECKSUM_EN appends a modulo-256 sum byte to every frame.
module ann_frame_assembler
  import ann_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_data,
  input  logic                     byte_en,
  output logic                     frame_ok,
  output logic                     frame_bad,
  output logic [FRAME_BYTES*8-1:0] frame_data
);
  localparam int W = FRAME_BYTES * 8;

`ifdef ANN_FRAME_CHECKSUM_EN
  localparam logic [4:0] LAST = 5'(FRAME_BYTES);
`else
  localparam logic [4:0] LAST = 5'(FRAME_BYTES - 1);
`endif

  logic [4:0]   cnt;
  logic [W-1:0] shadow;
  logic         last;

  assign last = byte_en && (cnt == LAST);

`ifdef ANN_FRAME_CHECKSUM_EN
  logic [7:0] sum;

  assign frame_ok   = last && (byte_data == sum);
  assign frame_bad  = last && (byte_data != sum);
  assign frame_data = shadow;

  always_ff @(posedge clk) begin
    if (rst || last) begin
      sum <= '0;
    end else if (byte_en) begin
      sum <= sum + byte_data;
    end
  end
`else
  // Top byte of the shadow is still zero when the final byte arrives.
  assign frame_ok   = last;
  assign frame_bad  = 1'b0;
  assign frame_data = {shadow[W-1:W-8] | byte_data,
                       shadow[W-9:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst || last) begin
      cnt    <= '0;
      shadow <= '0;
    end else if (byte_en) begin
      cnt <= cnt + 5'd1;
      shadow[{cnt[3:0], 3'b000} +: 8] <= byte_data;
    end
  end
endmodule

// File: rtl/ann_feature_loader.sv
// Loads byte-serial feature frames, lets the classifier settle, captures
// its stage and hands it out on a valid/ready port. Macro: ANN_FRAME_CHECKSUM_EN.
module ann_feature_loader
  import ann_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int N_FEAT        = ann_pkg::N_FEAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N_FEAT*FEAT_W-1:0]   feat_bus,
  input  logic [STAGE_W-1:0]         stage_in,
  output logic [STAGE_W-1:0]         res_stage,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       frame_err
);
  state_t                    state_q;
  state_t                    state_d;
  logic [7:0]                settle_cnt;
  logic                      settle_done;
  logic                      byte_en;
  logic                      frame_ok;
  logic                      frame_bad;
  logic [N_FEAT*FEAT_W-1:0]  frame_data;

  assign byte_en     = in_valid && in_ready;
  assign settle_done = (settle_cnt == 8'(SETTLE_CYCLES - 1));

  ann_frame_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .byte_data  (in_data),
    .byte_en    (byte_en),
    .frame_ok   (frame_ok),
    .frame_bad  (frame_bad),
    .frame_data (frame_data)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      RECV: begin
        in_ready = 1'b1;
        if (frame_ok) state_d = SETTLE;
      end
      SETTLE:  if (settle_done) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (res_ready) state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RECV;
      settle_cnt <= '0;
      feat_bus   <= '0;
      res_stage  <= '0;
      res_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_err <= frame_bad;
      if (frame_ok) feat_bus <= frame_data;
      if (state_q == SETTLE) begin
        settle_cnt <= settle_done ? 8'd0 : settle_cnt + 8'd1;
      end
      if (state_q == CAPTURE) begin
        res_stage <= stage_in;
        res_valid <= 1'b1;
      end else if (state_q == RESP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ann_feature_loader.sv
// Self-checking bench for ann_feature_loader: vector table plus
// hand-written stall, reset and checksum sequences with a result scoreboard.
module tb_ann_feature_loader;
  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] feat_bus;
  logic [1:0]   cls_stage;
  logic [1:0]   res_stage;
  logic         res_valid;
  logic         res_ready;
  logic         frame_err;

  always #5 clk = ~clk;

  ann_feature_loader #(.SETTLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .feat_bus  (feat_bus),
    .stage_in  (cls_stage),
    .res_stage (res_stage),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .frame_err (frame_err)
  );

  typedef logic [0:15][7:0] frame_t;
  typedef struct {
    frame_t       bytes;
    logic [127:0] feat;
    logic [1:0]   stage;
  } vec_t;
  typedef struct {
    logic [127:0] feat;
    logic [1:0]   stage;
  } exp_t;

`ifdef ANN_FRAME_CHECKSUM_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif
  localparam int LAT = 6;

  exp_t         sb[$];
  vec_t         v[4];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  int           results = 0;
  int           err_pulses = 0;
  int           hs_cyc;
  int           first_hs;
  logic [127:0] cur_feat;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst && res_valid && res_ready) begin
      exp_t e;
      results++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d required=none",
                 res_stage);
      end else begin
        e = sb.pop_front();
        chk("sb_stage", 128'(res_stage), 128'(e.stage));
        chk("sb_feat", feat_bus, e.feat);
      end
    end
    if (!rst && frame_err) err_pulses++;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'd1);
    hs_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input logic [127:0] exp,
                            input logic [1:0] stg, input bit corrupt);
`ifdef ANN_FRAME_CHECKSUM_EN
    logic [7:0] sum = 8'd0;
`endif
    cls_stage = stg;
    for (int i = 0; i < 16; i++) begin
      send_byte(f[i]);
      if (i == 0) first_hs = hs_cyc;
      if (i == 8) chk("atomic_hold", feat_bus, cur_feat);
`ifdef ANN_FRAME_CHECKSUM_EN
      sum = sum + f[i];
`endif
    end
`ifdef ANN_FRAME_CHECKSUM_EN
    send_byte(corrupt ? sum + 8'd1 : sum);
`endif
    if (corrupt) begin
      chk("bad_csum_feat_kept", feat_bus, cur_feat);
      chk("bad_csum_err_high", 128'(frame_err), 128'd1);
      chk("bad_csum_in_ready", 128'(in_ready), 128'd1);
    end else begin
      sb.push_back('{exp, stg});
      chk("feat_commit", feat_bus, exp);
      cur_feat = exp;
    end
  endtask

  task automatic wait_valid(output int vc);
    int n = 0;
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk("res_valid_timeout", 128'(res_valid), 128'd1);
    vc = cyc;
  endtask

  initial begin
    int vc;
    int prev_vc;
    int r0;
    v[0] = '{{112'h0, 8'h2A, 8'h00}, {16'h002A, 112'h0}, 2'd2};
    v[1] = '{{8'h18, 8'hFC, 112'h0}, {112'h0, 16'hFC18}, 2'd1};
    v[2] = '{{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00,
              8'h05, 8'h00, 8'h06, 8'h00, 8'h07, 8'h00, 8'h08, 8'h00},
             {16'h0008, 16'h0007, 16'h0006, 16'h0005,
              16'h0004, 16'h0003, 16'h0002, 16'h0001}, 2'd3};
    v[3] = '{{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE,
              8'h11, 8'h00, 8'h22, 8'h00, 8'h33, 8'h00, 8'h44, 8'h00},
             {16'h0044, 16'h0033, 16'h0022, 16'h0011,
              16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234}, 2'd0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    res_ready = 1'b1; cls_stage = 2'd0; cur_feat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_feat", feat_bus, 128'd0);
    chk("rst_res_valid", 128'(res_valid), 128'd0);
    chk("rst_res_stage", 128'(res_stage), 128'd0);
    chk("rst_frame_err", 128'(frame_err), 128'd0);

    // Back-to-back table frames with res_ready held high
    prev_vc = 0;
    for (int i = 0; i < 4; i++) begin
      send_frame(v[i].bytes, v[i].feat, v[i].stage, 1'b0);
      if (i == 1)
        chk("f0_minus1000", 128'(feat_bus[15:0]), 128'(16'hFC18));
      wait_valid(vc);
      chk("latency", 128'(vc - hs_cyc), 128'(LAT));
      chk("res_stage", 128'(res_stage), 128'(v[i].stage));
      if (i > 0) chk("b2b_gap", 128'(first_hs - prev_vc), 128'd1);
      prev_vc = vc;
    end
    @(negedge clk);

    // Consumer stall with host pushing bytes and classifier changing
    res_ready = 1'b0;
    send_frame(v[2].bytes, v[2].feat, v[2].stage, 1'b0);
    wait_valid(vc);
    chk("stall_latency", 128'(vc - hs_cyc), 128'(LAT));
    cls_stage = 2'd1;
    in_data = 8'h55;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_valid", 128'(res_valid), 128'd1);
      chk("stall_stage", 128'(res_stage), 128'd3);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    send_frame(v[3].bytes, v[3].feat, v[3].stage, 1'b0);
    wait_valid(vc);
    @(negedge clk);

    // Reset while a result is pending
    res_ready = 1'b0;
    send_frame(v[0].bytes, v[0].feat, v[0].stage, 1'b0);
    wait_valid(vc);
    void'(sb.pop_back());
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cur_feat = '0;
    chk("resp_rst_valid", 128'(res_valid), 128'd0);
    chk("resp_rst_feat", feat_bus, 128'd0);
    chk("resp_rst_in_ready", 128'(in_ready), 128'd1);

    // Reset after nine bytes, then one full frame
    res_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(v[2].bytes[i]);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_feat", feat_bus, 128'd0);
    r0 = results;
    send_frame(v[0].bytes, v[0].feat, v[0].stage, 1'b0);
    wait_valid(vc);
    chk("mid_rst_latency", 128'(vc - hs_cyc), 128'(LAT));
    repeat (20) @(negedge clk);
    chk("mid_rst_one_result", 128'(results - r0), 128'd1);

`ifdef ANN_FRAME_CHECKSUM_EN
    send_frame(v[1].bytes, v[1].feat, v[1].stage, 1'b1);
    @(negedge clk);
    chk("bad_csum_err_pulse", 128'(frame_err), 128'd0);
    chk("bad_csum_no_result", 128'(res_valid), 128'd0);
    send_frame(v[1].bytes, v[1].feat, v[1].stage, 1'b0);
    wait_valid(vc);
    chk("csum_latency", 128'(vc - hs_cyc), 128'(LAT));
    @(negedge clk);
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty", 128'(sb.size()), 128'd0);
    chk("err_pulses", 128'(err_pulses), 128'(EXP_ERR));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ann_feature_loader.md
ANN_FEATURE_LOADER -- requirements
Module: ann_feature_loader

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: clock cycles between features becoming stable and sampling the classifier result (range 1..255).
REQ-002 SHALL have parameter N_FEAT, default 8: features per frame; value taken from the shared package.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8: host byte stream.
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_ready, output, 1: loader accepts a byte.
REQ-008 SHALL have port feat_bus, output, 128: f0 in [15:0] through f7 in [127:112], each signed 16-bit, driven to the classifier feature inputs.
REQ-009 SHALL have port stage_in, input, 2: combinational predicted_stage returned by the classifier.
REQ-010 SHALL have port res_stage, output, 2: captured stage.
REQ-011 SHALL have port res_valid, output, 1: res_stage valid.
REQ-012 SHALL have port res_ready, input, 1: consumer accepts the result.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a rejected frame.

Function
REQ-014 SHALL accept a byte only on a cycle where in_valid and in_ready are both 1.
REQ-015 SHALL use states RECV, SETTLE, CAPTURE, RESP, entering RECV after reset.
REQ-016 In RECV, in_ready SHALL be 1 and bytes SHALL be assembled little-endian per feature, f0 first, 2*N_FEAT = 16 bytes per frame.
REQ-017 Bytes SHALL go to a shadow register, and feat_bus SHALL update atomically, all 128 bits in one cycle, only when a frame completes.
REQ-018 On the accepting cycle of the final byte, the loader SHALL commit feat_bus and move to SETTLE on the next edge.
REQ-019 SETTLE SHALL count SETTLE_CYCLES cycles, then enter CAPTURE.
REQ-020 CAPTURE SHALL register stage_in into res_stage, set res_valid=1, and go to RESP, taking exactly 1 cycle.
REQ-021 In RESP, res_valid and res_stage SHALL hold until res_valid and res_ready are both 1; on that cycle res_valid drops next edge and the state returns to RECV.
REQ-022 Latency from the last-byte handshake to res_valid=1 SHALL be SETTLE_CYCLES+2 cycles.
REQ-023 in_ready SHALL be 0 in SETTLE, CAPTURE and RESP, so no bytes are accepted until the result is consumed.
REQ-024 feat_bus SHALL hold its last committed frame through all states until the next frame completes.
REQ-025 If res_ready is already 1 when res_valid rises, the handshake SHALL complete in that same cycle.
REQ-026 The byte counter SHALL wrap to 0 after each frame; no partial-frame state SHALL persist across frames.

Reset
REQ-027 On rst=1 at a clock edge: state=RECV, byte counter=0, shadow=0, feat_bus=0, res_stage=0, res_valid=0, frame_err=0, SETTLE counter=0.
REQ-028 After reset, in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-029 Reset mid-frame or mid-RESP SHALL discard all partial or pending data; no result SHALL be emitted.

Configuration
REQ-030 Macro ANN_FRAME_CHECKSUM_EN defined: frame = 16 data bytes + 1 checksum byte; checksum = 8-bit modulo-256 sum of the data bytes.
REQ-031 On checksum match, the loader SHALL behave per REQ-018, counted from the checksum byte handshake.
REQ-032 On checksum mismatch, the loader SHALL not update feat_bus, SHALL pulse frame_err for 1 cycle, SHALL stay in RECV, and SHALL reset the byte counter to 0.
REQ-033 Macro undefined: 16-byte frames, no checksum, frame_err tied to 0.

Structure
REQ-034 Package ann_pkg SHALL hold N_FEAT=8, FEAT_W=16, STAGE_W=2, FRAME_BYTES=2*N_FEAT, and the state enum type.
REQ-035 Sub-module ann_frame_assembler SHALL own the byte counter, shadow register and checksum; the top level SHALL own the FSM and result handshake.
REQ-036 The classifier SHALL not be instantiated inside this block; the bench connects it.

Verification
REQ-037 Frame bytes 0x00 x14, 0x2A, 0x00 with the classifier returning 2 -> feat_bus[127:112]=16'sd42, all other bits 0, res_stage=2, res_valid rising 6 cycles after the last byte.
REQ-038 Bytes 0x18, 0xFC as f0 -> feat_bus[15:0]=16'shFC18 (-1000), sign preserved.
REQ-039 res_ready held 0 for 10 cycles -> res_valid and res_stage stable, in_ready=0 with in_valid=1 held, and no bytes consumed.
REQ-040 rst asserted after byte 9 of a frame, then a full new frame sent -> only the new frame appears on feat_bus, and exactly one result is produced.
REQ-041 With ANN_FRAME_CHECKSUM_EN, a bad checksum byte (correct value +1) -> frame_err pulses once, feat_bus is unchanged, and the next good frame is accepted normally.
REQ-042 Two back-to-back frames with res_ready=1 constantly -> two results in order, the second frame's first byte accepted 1 cycle after the first result handshake.
